// File: rtl/inst_encoder_pkg.sv
// Shared instruction types for the RV32I request encoder: formats, NOP word,
// request/FIFO payloads and an immediate range helper.
package inst_encoder_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned FMT_W  = 3;

  typedef logic [XLEN-1:0] instr_t;

  localparam instr_t NOP = 32'h0000_0013;

  typedef enum logic [FMT_W-1:0] {
    FMT_R      = 3'd0,
    FMT_I      = 3'd1,
    FMT_ISHIFT = 3'd2,
    FMT_S      = 3'd3,
    FMT_B      = 3'd4,
    FMT_U      = 3'd5,
    FMT_J      = 3'd6,
    FMT_CSR    = 3'd7
  } fmt_e;

  typedef struct packed {
    fmt_e              fmt;
    logic [OP_W-1:0]   opcode;
    logic [F3_W-1:0]   funct3;
    logic              funct7b5;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [XLEN-1:0]   imm;
  } req_t;

  typedef struct packed {
    instr_t inst;
    logic   err;
  } fifo_entry_t;

  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

  // True when v is representable as a two's-complement number of 'bits' bits.
  function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned bits);
    logic [XLEN-1:0] hi;
    hi = XLEN'($signed(v) >>> (bits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_sync_fifo.sv
// Single-clock FIFO with synchronous reset and clear; push ignored when full,
// pop ignored when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: one request stage, range/field check, and an
// output FIFO of {word, error} entries with a saturating reject counter.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FMT_W-1:0]  req_format,
  input  logic [OP_W-1:0]   req_opcode,
  input  logic [F3_W-1:0]   req_funct3,
  input  logic              req_funct7b5,
  input  logic [REG_W-1:0]  req_rd,
  input  logic [REG_W-1:0]  req_rs1,
  input  logic [REG_W-1:0]  req_rs2,
  input  logic [XLEN-1:0]   req_imm,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   inst,
  output logic              inst_err,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  req_t        req;
  req_t        s1_q;
  logic        s1_valid;
  logic        accept;
  logic        drain;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fifo_entry_t s1_entry;
  fifo_entry_t head;
  instr_t      enc;
  logic        ok;

  assign req = '{
    fmt:      fmt_e'(req_format),
    opcode:   req_opcode,
    funct3:   req_funct3,
    funct7b5: req_funct7b5,
    rd:       req_rd,
    rs1:      req_rs1,
    rs2:      req_rs2,
    imm:      req_imm
  };

  // A full FIFO only blocks new requests once S1 is also occupied.
  assign req_ready = !flush && (!s1_valid || !fifo_full);
  assign accept    = req_valid && req_ready;
  assign drain     = s1_valid && !fifo_full && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (drain) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) s1_q <= req;
  end

  // Encode and range-check the S1 request; ok=0 replaces the word with NOP.
  always_comb begin
    enc = NOP;
    ok  = 1'b0;
    case (s1_q.fmt)
      FMT_R: begin
        enc = {(s1_q.funct7b5 ? 7'h20 : 7'h00), s1_q.rs2, s1_q.rs1,
               s1_q.funct3, s1_q.rd, s1_q.opcode};
        ok  = 1'b1;
      end
      FMT_I: begin
        enc = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
        ok  = fits_signed(s1_q.imm, 12);
      end
      FMT_ISHIFT: begin
        enc = {1'b0, s1_q.funct7b5, 5'b0_0000, s1_q.imm[4:0], s1_q.rs1,
               s1_q.funct3, s1_q.rd, s1_q.opcode};
        ok  = (s1_q.imm[31:5] == '0) &&
              ((s1_q.funct3 == 3'b001) || (s1_q.funct3 == 3'b101));
      end
      FMT_S: begin
        enc = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
               s1_q.imm[4:0], s1_q.opcode};
        ok  = fits_signed(s1_q.imm, 12);
      end
      FMT_B: begin
        enc = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
               s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
        ok  = fits_signed(s1_q.imm, 13) && !s1_q.imm[0];
      end
      FMT_U: begin
        enc = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
        ok  = (s1_q.imm[11:0] == '0);
      end
      FMT_J: begin
        enc = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12],
               s1_q.rd, s1_q.opcode};
        ok  = fits_signed(s1_q.imm, 21) && !s1_q.imm[0];
      end
      FMT_CSR: begin
        enc = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
        ok  = (s1_q.imm[31:12] == '0);
      end
      default: begin
        enc = NOP;
        ok  = 1'b0;
      end
    endcase
  end

  assign s1_entry.inst = ok ? enc : NOP;
  assign s1_entry.err  = !ok;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (drain),
    .push_data (s1_entry),
    .pop       (inst_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign inst_valid = !fifo_empty;
  assign inst       = head.inst;
  assign inst_err   = head.err && !fifo_empty;

  // Rejects are counted as they leave S1; flushed requests never count.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (drain && !ok && (err_count != '1)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert ((fifo_count == '0) == fifo_empty);
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a queue-based behavioural model checked
// every cycle, plus hand-computed literal expectations.
module tb_inst_encoder;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ERR_W   = 2;
  localparam int          ERR_MAX = (1 << ERR_W) - 1;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst, flush, req_valid, req_ready, req_funct7b5;
  logic [2:0]       req_format, req_funct3;
  logic [6:0]       req_opcode;
  logic [4:0]       req_rd, req_rs1, req_rs2;
  logic [31:0]      req_imm, inst;
  logic             inst_valid, inst_ready, inst_err;
  logic [ERR_W-1:0] err_count;

  int n_vec = 0;
  int n_bad = 0;

  ent_t q[$];
  ent_t m_s1;
  bit   m_s1v   = 0;
  int   m_err   = 0;
  bit   started = 0;

  inst_encoder #(.FIFO_DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_format(req_format), .req_opcode(req_opcode), .req_funct3(req_funct3),
    .req_funct7b5(req_funct7b5), .req_rd(req_rd), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_err(inst_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op,
                              input logic [2:0] f3, input logic b5, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
    vec_t v;
    v.fmt = fmt; v.op = op; v.f3 = f3; v.b5 = b5;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    return v;
  endfunction

  // Architectural reference: fields are placed by shifting and masking, and
  // ranges are tested as ordinary signed/unsigned integers.
  function automatic ent_t model_enc(input vec_t v);
    ent_t        e;
    logic [31:0] imm, rd, rs1, rs2, f3, op, b5;
    longint      s;
    bit          ok;
    imm = v.imm; rd = 32'(v.rd); rs1 = 32'(v.rs1); rs2 = 32'(v.rs2);
    f3 = 32'(v.f3); op = 32'(v.op); b5 = v.b5 ? 32'h4000_0000 : 32'h0;
    s = longint'($signed(v.imm));
    ok = 1'b1;
    e.inst = 32'h0;
    case (v.fmt)
      3'd0: e.inst = b5 | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        e.inst = ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      3'd2: begin
        ok = (v.imm <= 31) && ((v.f3 == 3'd1) || (v.f3 == 3'd5));
        e.inst = b5 | ((imm & 32'h1f) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      3'd3: begin
        ok = (s >= -2048) && (s <= 2047);
        e.inst = (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                 ((imm & 32'h1f) << 7) | op;
      end
      3'd4: begin
        ok = (s >= -4096) && (s <= 4094) && (v.imm[0] == 1'b0);
        e.inst = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25) |
                 (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hf) << 8) |
                 (((imm >> 11) & 32'h1) << 7) | op;
      end
      3'd5: begin
        ok = ((imm & 32'hfff) == 0);
        e.inst = (imm & 32'hffff_f000) | (rd << 7) | op;
      end
      3'd6: begin
        ok = (s >= -(longint'(1) << 20)) && (s <= (longint'(1) << 20) - 2) && (v.imm[0] == 1'b0);
        e.inst = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3ff) << 21) |
                 (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hff) << 12) |
                 (rd << 7) | op;
      end
      default: begin
        ok = (v.imm <= 4095);
        e.inst = (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
    endcase
    if (!ok) e.inst = 32'h0000_0013;
    e.err = !ok;
    return e;
  endfunction

  // Cycle model: S1 slot plus a bounded queue, updated from pre-edge state.
  always @(posedge clk) begin : mdl
    bit   full, acc, drn;
    vec_t v;
    if (rst) begin
      q.delete(); m_s1v = 0; m_err = 0; started = 1;
    end else if (flush) begin
      q.delete(); m_s1v = 0;
    end else begin
      full = (q.size() == DEPTH);
      acc  = req_valid && (!m_s1v || !full);
      drn  = m_s1v && !full;
      if (inst_ready && q.size() != 0) void'(q.pop_front());
      if (drn) begin
        q.push_back(m_s1);
        if (m_s1.err && m_err < ERR_MAX) m_err++;
      end
      if (acc) begin
        v = mk(req_format, req_opcode, req_funct3, req_funct7b5, req_rd, req_rs1,
               req_rs2, req_imm);
        m_s1  = model_enc(v);
        m_s1v = 1;
      end else if (drn) begin
        m_s1v = 0;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      check("req_ready", 32'(req_ready), 32'(!flush && (!m_s1v || q.size() < DEPTH)));
      check("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
      check("inst_err", 32'(inst_err), (q.size() != 0) ? 32'(q[0].err) : 32'h0);
      if (q.size() != 0) check("inst", inst, q[0].inst);
      check("err_count", 32'(err_count), 32'(m_err));
    end
  end

  task automatic set_req(input vec_t v);
    req_valid = 1'b1; req_format = v.fmt; req_opcode = v.op; req_funct3 = v.f3;
    req_funct7b5 = v.b5; req_rd = v.rd; req_rs1 = v.rs1; req_rs2 = v.rs2; req_imm = v.imm;
  endtask

  // Present a request until it is taken; returns just after the accepting edge.
  task automatic send(input vec_t v);
    bit got;
    set_req(v);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      got = req_ready;
      @(posedge clk);
      #1;
      if (got) return;
    end
    n_vec++; n_bad++;
    $display("FAIL send_timeout: got no acceptance expected acceptance within 64 cycles");
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  vec_t v_add, v_addi, v_srai, v_lui, v_beq3, v_i2048;
  vec_t tbl[20];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    v_add   = mk(3'd0, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    v_addi  = mk(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hffff_ffff);
    v_srai  = mk(3'd2, 7'h13, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3);
    v_lui   = mk(3'd5, 7'h37, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1234_5000);
    v_beq3  = mk(3'd4, 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    v_i2048 = mk(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);

    tbl[0]  = mk(3'd0, 7'h33, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0);
    tbl[1]  = mk(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd2047);
    tbl[2]  = mk(3'd1, 7'h13, 3'd0, 1'b0, 5'd2, 5'd3, 5'd0, 32'hffff_f800);
    tbl[3]  = mk(3'd1, 7'h13, 3'd0, 1'b0, 5'd3, 5'd4, 5'd0, 32'hffff_f7ff);
    tbl[4]  = mk(3'd3, 7'h23, 3'd2, 1'b0, 5'd0, 5'd3, 5'd4, 32'hffff_ffff);
    tbl[5]  = mk(3'd3, 7'h23, 3'd2, 1'b0, 5'd0, 5'd3, 5'd4, 32'd2048);
    tbl[6]  = mk(3'd4, 7'h63, 3'd1, 1'b0, 5'd0, 5'd8, 5'd9, 32'd4094);
    tbl[7]  = mk(3'd4, 7'h63, 3'd0, 1'b0, 5'd0, 5'd8, 5'd9, 32'hffff_f000);
    tbl[8]  = mk(3'd4, 7'h63, 3'd0, 1'b0, 5'd0, 5'd8, 5'd9, 32'd4096);
    tbl[9]  = mk(3'd6, 7'h6f, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h000f_fffe);
    tbl[10] = mk(3'd6, 7'h6f, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hfff0_0000);
    tbl[11] = mk(3'd6, 7'h6f, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0010_0000);
    tbl[12] = mk(3'd5, 7'h37, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'hffff_f000);
    tbl[13] = mk(3'd5, 7'h17, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h0000_1001);
    tbl[14] = mk(3'd2, 7'h13, 3'd1, 1'b0, 5'd11, 5'd12, 5'd0, 32'd31);
    tbl[15] = mk(3'd2, 7'h13, 3'd5, 1'b0, 5'd11, 5'd12, 5'd0, 32'd32);
    tbl[16] = mk(3'd2, 7'h13, 3'd0, 1'b0, 5'd11, 5'd12, 5'd0, 32'd5);
    tbl[17] = mk(3'd7, 7'h73, 3'd1, 1'b0, 5'd13, 5'd14, 5'd0, 32'd4095);
    tbl[18] = mk(3'd7, 7'h73, 3'd1, 1'b0, 5'd13, 5'd14, 5'd0, 32'd4096);
    tbl[19] = mk(3'd0, 7'h33, 3'd7, 1'b0, 5'd15, 5'd16, 5'd17, 32'd0);

    // Pin the model against hand-encoded words.
    check("pin_add",  model_enc(v_add).inst,  32'h0020_81B3);
    check("pin_addi", model_enc(v_addi).inst, 32'hFFF0_0093);
    check("pin_srai", model_enc(v_srai).inst, 32'h4033_5293);
    check("pin_lui",  model_enc(v_lui).inst,  32'h1234_50B7);
    check("pin_beq3", {model_enc(v_beq3).inst[30:0], model_enc(v_beq3).err}, 32'h0000_0027);
    check("pin_bneg", model_enc(mk(3'd4, 7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0,
                                   32'hffff_f000)).inst, 32'h8000_0063);
    check("pin_j2048", model_enc(mk(3'd6, 7'h6f, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0,
                                    32'd2048)).inst, 32'h0010_006F);

    rst = 1'b1; flush = 1'b0; inst_ready = 1'b0;
    set_req(v_add); req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst_err", 32'(inst_err), 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);

    // Two-edge latency for ADD.
    inst_ready = 1'b1;
    set_req(v_add);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("add_lat1_valid", 32'(inst_valid), 32'h0);
    @(posedge clk);
    #1;
    check("add_lat2_valid", 32'(inst_valid), 32'h1);
    check("add_word", inst, 32'h0020_81B3);
    check("add_err", 32'(inst_err), 32'h0);
    idle(2);

    send(v_addi); send(v_srai); send(v_lui);
    idle(4);

    send(v_beq3); send(v_i2048);
    idle(4);
    check("two_rejects", 32'(err_count), 32'h2);

    // Backpressure: four in the FIFO plus one in S1, sixth blocked.
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(mk(3'd1, 7'h13, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i * 10)));
    set_req(mk(3'd1, 7'h13, 3'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'd50));
    #1;
    check("sixth_blocked", 32'(req_ready), 32'h0);
    check("bp_head", inst, 32'h0000_0093);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    inst_ready = 1'b1;
    send(mk(3'd1, 7'h13, 3'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'd50));
    idle(8);

    // Flush with a full FIFO and a request on the same cycle.
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(mk(3'd1, 7'h13, 3'd0, 1'b0, 5'(i + 8), 5'd1, 5'd0, 32'(i)));
    set_req(mk(3'd1, 7'h13, 3'd0, 1'b0, 5'd20, 5'd1, 5'd0, 32'd7));
    flush = 1'b1;
    #1;
    check("flush_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0; req_valid = 1'b0;
    check("flush_empty", 32'(inst_valid), 32'h0);
    check("flush_errcnt", 32'(err_count), 32'h2);
    idle(3);

    // Reset with three entries buffered.
    for (int i = 0; i < 3; i++)
      send(mk(3'd0, 7'h33, 3'd0, 1'b0, 5'(i + 1), 5'd2, 5'd3, 32'd0));
    idle(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstmid_valid", 32'(inst_valid), 32'h0);
    check("rstmid_ready", 32'(req_ready), 32'h1);
    check("rstmid_errcnt", 32'(err_count), 32'h0);

    // Boundary table with a stuttering consumer.
    for (int i = 0; i < 20; i++) begin
      inst_ready = (i % 3) != 0;
      send(tbl[i]);
    end
    inst_ready = 1'b1;
    idle(12);
    check("errcnt_saturated", 32'(err_count), 32'(ERR_MAX));
    check("drained", 32'(inst_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
